// File: rtl/flit_buffer_if.sv
// Handshake and status bundle between an upstream producer and the flit buffer.
// The master side drives push/pop requests and data; the slave side is the buffer.
interface flit_buffer_if #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1)
);
  logic                  receive_i;
  logic                  send_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [CNT_W-1:0]      count_o;
  logic                  overflow_o;

  modport master (
    output receive_i, send_i, data_i,
    input  data_o, valid_o, full_o, almost_full_o, count_o, overflow_o
  );

  modport slave (
    input  receive_i, send_i, data_i,
    output data_o, valid_o, full_o, almost_full_o, count_o, overflow_o
  );
endinterface

// File: rtl/flit_buffer.sv
// Multi-entry in-order flit buffer with occupancy, full/almost-full status and a
// sticky overflow flag. Head flit is read combinationally from registered storage.
module flit_buffer #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic          clk,
  input logic          rst,
  flit_buffer_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;

  logic [PTR_W-1:0]      wr_ptr_s;
  logic [PTR_W-1:0]      rd_ptr_s;
  logic [CNT_W-1:0]      count_s;
  logic                  overflow_s;
  logic                  valid_s;
  logic                  full_s;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Status decode from the occupancy register only.
  always_comb begin
    valid_s   = (count_r != {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    push_ok_s = bus.receive_i & (~full_s | bus.send_i);
    pop_ok_s  = bus.send_i & valid_s;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    overflow_s = overflow_r;

    if (push_ok_s) begin
      wr_ptr_s = (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    if (pop_ok_s) begin
      rd_ptr_s = (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase

    // A push request that was not accepted means a flit was lost.
    if (bus.receive_i && !push_ok_s) begin
      overflow_s = 1'b1;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      overflow_r <= overflow_s;
    end
  end

  // Storage array; contents need no reset because the output is masked by valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= bus.data_i;
    end
  end

  assign bus.data_o        = mem_r[rd_ptr_r] & {DATA_WIDTH{valid_s}};
  assign bus.valid_o       = valid_s;
  assign bus.full_o        = full_s;
  assign bus.almost_full_o = (count_r == CNT_W'(DEPTH - 1));
  assign bus.count_o       = count_r;
  assign bus.overflow_o    = overflow_r;

endmodule

// File: tb/tb_flit_buffer.sv
// Scoreboard-based bench for flit_buffer: accepted pushes are queued as expected
// flits and compared against data_o whenever a pop is accepted.
module tb_flit_buffer;
  localparam int DW    = 17;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [DW-1:0] sb_q [$];
  logic          model_ovf;

  flit_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  flit_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; returns data_o seen before the edge and the scoreboard head it should match.
  task automatic step(input logic rcv, input logic snd, input logic [DW-1:0] din,
                      output logic [DW-1:0] obs, output logic [DW-1:0] exp, output logic popped);
    logic push_ok;
    logic pop_ok;
    bus.receive_i = rcv;
    bus.send_i    = snd;
    bus.data_i    = din;
    @(negedge clk);
    obs     = bus.data_o;
    push_ok = rcv && ((sb_q.size() < DEPTH) || snd);
    pop_ok  = snd && (sb_q.size() > 0);
    popped  = pop_ok;
    exp     = {DW{1'b0}};
    if (pop_ok) exp = sb_q.pop_front();
    if (push_ok) sb_q.push_back(din);
    if (rcv && !push_ok) model_ovf = 1'b1;
    @(posedge clk);
    #1;
    bus.receive_i = 1'b0;
    bus.send_i    = 1'b0;
    bus.data_i    = {DW{1'b0}};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.receive_i = 1'b0;
    bus.send_i    = 1'b0;
    bus.data_i    = {DW{1'b0}};
    sb_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.count_o !== CW'(0) || bus.valid_o !== 1'b0 || bus.data_o !== {DW{1'b0}} ||
        bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b data=%h full=%b af=%b ovf=%b, required all zero",
               bus.count_o, bus.valid_o, bus.data_o, bus.full_o, bus.almost_full_o, bus.overflow_o);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4];
    logic [DW-1:0] obs, exp;
    logic popped;
    vals[0] = 17'h00011; vals[1] = 17'h00022; vals[2] = 17'h00033; vals[3] = 17'h00044;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, vals[i], obs, exp, popped);
      checks++;
      if (bus.count_o !== CW'(i + 1) || bus.data_o !== 17'h00011 || bus.valid_o !== 1'b1 ||
          bus.almost_full_o !== (i == 2) || bus.full_o !== (i == 3)) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d data=%h af=%b full=%b, required count=%0d data=00011 af=%b full=%b",
                 i, bus.count_o, bus.data_o, bus.almost_full_o, bus.full_o, i + 1, (i == 2), (i == 3));
      end
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] next_head [4];
    logic [DW-1:0] obs, exp;
    logic popped;
    next_head[0] = 17'h00022; next_head[1] = 17'h00033; next_head[2] = 17'h00044; next_head[3] = 17'h00000;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, {DW{1'b0}}, obs, exp, popped);
      checks++;
      if (!popped || obs !== exp) begin
        errors++;
        $display("FAIL drain_pop_%0d: got %h, required %h", i, obs, exp);
      end
      checks++;
      if (bus.data_o !== next_head[i] || bus.valid_o !== (i != 3) || bus.count_o !== CW'(3 - i)) begin
        errors++;
        $display("FAIL drain_head_%0d: data=%h valid=%b count=%0d, required data=%h valid=%b count=%0d",
                 i, bus.data_o, bus.valid_o, bus.count_o, next_head[i], (i != 3), 3 - i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] obs, exp;
    logic popped;
    // Push and pop together on an empty buffer: pop ignored, push lands.
    step(1'b1, 1'b1, 17'h00100, obs, exp, popped);
    checks++;
    if (bus.count_o !== CW'(1) || bus.data_o !== 17'h00100) begin
      errors++;
      $display("FAIL empty_push_pop: count=%0d data=%h, required count=1 data=00100", bus.count_o, bus.data_o);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, DW'(17'h00100 + i), obs, exp, popped);
      checks++;
      if (!popped || obs !== exp || exp !== DW'(17'h00100 + i - 1) || bus.count_o !== CW'(1)) begin
        errors++;
        $display("FAIL wrap_%0d: popped %h count=%0d, required %h count=1",
                 i, obs, bus.count_o, DW'(17'h00100 + i - 1));
      end
    end
    step(1'b0, 1'b1, {DW{1'b0}}, obs, exp, popped);
    checks++;
    if (obs !== exp || bus.count_o !== CW'(0)) begin
      errors++;
      $display("FAIL wrap_last: got %h count=%0d, required %h count=0", obs, bus.count_o, exp);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] obs, exp;
    logic popped;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(17'h00201 + i), obs, exp, popped);
    step(1'b1, 1'b1, 17'h1ABCD, obs, exp, popped);
    checks++;
    if (bus.count_o !== CW'(4) || bus.overflow_o !== 1'b0 || obs !== 17'h00201) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%b popped=%h, required count=4 ovf=0 popped=00201",
               bus.count_o, bus.overflow_o, obs);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, {DW{1'b0}}, obs, exp, popped);
      checks++;
      if (obs !== exp || (i == 3 && obs !== 17'h1ABCD)) begin
        errors++;
        $display("FAIL full_push_pop_drain_%0d: got %h, required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] obs, exp;
    logic popped;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(17'h00301 + i), obs, exp, popped);
    step(1'b1, 1'b0, 17'h0DEAD, obs, exp, popped);
    checks++;
    if (bus.overflow_o !== 1'b1 || model_ovf !== 1'b1 || bus.count_o !== CW'(4)) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b count=%0d, required ovf=1 count=4", bus.overflow_o, bus.count_o);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, {DW{1'b0}}, obs, exp, popped);
      checks++;
      if (obs !== exp || bus.overflow_o !== 1'b1 ||
          bus.count_o !== CW'((i < 4) ? 3 - i : 0)) begin
        errors++;
        $display("FAIL overflow_drain_%0d: got %h count=%0d ovf=%b, required %h count=%0d ovf=1",
                 i, obs, bus.count_o, bus.overflow_o, exp, (i < 4) ? 3 - i : 0);
      end
    end
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== {DW{1'b0}}) begin
      errors++;
      $display("FAIL empty_pop: valid=%b data=%h, required valid=0 data=0", bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] obs, exp;
    logic popped;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(17'h00401 + i), obs, exp, popped);
    #2;
    rst = 1'b0;
    #1;
    sb_q.delete();
    model_ovf = 1'b0;
    checks++;
    if (bus.count_o !== CW'(0) || bus.valid_o !== 1'b0 || bus.data_o !== {DW{1'b0}} ||
        bus.overflow_o !== 1'b0 || bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b data=%h ovf=%b, required all zero",
               bus.count_o, bus.valid_o, bus.data_o, bus.overflow_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 17'h00055, obs, exp, popped);
    step(1'b1, 1'b0, 17'h00066, obs, exp, popped);
    checks++;
    if (bus.data_o !== 17'h00055 || bus.count_o !== CW'(2)) begin
      errors++;
      $display("FAIL post_reset_push: data=%h count=%0d, required data=00055 count=2", bus.data_o, bus.count_o);
    end
    step(1'b0, 1'b1, {DW{1'b0}}, obs, exp, popped);
    checks++;
    if (obs !== exp || obs !== 17'h00055 || bus.data_o !== 17'h00066) begin
      errors++;
      $display("FAIL post_reset_pop: popped=%h head=%h, required popped=00055 head=00066", obs, bus.data_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_push_pop();
    test_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
